// File: rtl/unified_mem_arbiter.sv
// Shares the core's unified memory port with a loader/DMA requester.
// Serialises one transaction at a time with round-robin or fixed core-priority selection.
module unified_mem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_LAT   = 1,
    parameter int CORE_PRIO = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_done,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_gnt,
    output logic              l_done,
    output logic [DATA_W-1:0] l_rdata,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    state_t     state, state_nxt;
    logic       owner;      // 0 = core, 1 = loader
    logic       last_ldr;   // 1 = loader was served last
    logic [3:0] cnt;
    logic       sel_ldr;
    logic       any_req;
    logic       issue;
    logic       rd_done;
    logic       done;

    assign any_req = c_req | l_req;

    always_comb begin
        sel_ldr = 1'b0;
        if (l_req && !c_req)
            sel_ldr = 1'b1;
        else if (l_req && c_req)
            sel_ldr = (CORE_PRIO != 0) ? 1'b0 : !last_ldr;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ISSUE;
            ISSUE:   state_nxt = m_we ? IDLE : WAIT;
            WAIT:    if (cnt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            owner    <= 1'b0;
            last_ldr <= 1'b1;
            cnt      <= '0;
            m_we     <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner    <= sel_ldr;
                        last_ldr <= sel_ldr;
                        m_we     <= sel_ldr ? l_we    : c_we;
                        m_addr   <= sel_ldr ? l_addr  : c_addr;
                        m_wdata  <= sel_ldr ? l_wdata : c_wdata;
                    end
                end
                ISSUE:   cnt <= LAT_M1;
                WAIT:    if (cnt != '0) cnt <= cnt - 1'b1;
                default: cnt <= '0;
            endcase
        end
    end

    // All handshake strobes decode from registered state/owner, so there is no req-to-gnt path.
    assign issue   = (state == ISSUE);
    assign rd_done = (state == WAIT) && (cnt == '0);
    assign done    = (issue && m_we) || rd_done;

    assign m_en    = issue;
    assign busy    = (state != IDLE);
    assign c_gnt   = issue & ~owner;
    assign l_gnt   = issue &  owner;
    assign c_done  = done  & ~owner;
    assign l_done  = done  &  owner;
    assign c_rdata = (rd_done && !owner) ? m_rdata : '0;
    assign l_rdata = (rd_done &&  owner) ? m_rdata : '0;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter: four instances with differing MEM_LAT/CORE_PRIO,
// each backed by a latency-accurate memory model.
module tb_unified_mem_arbiter;

    localparam logic [15:0] LATS  = {4'd1, 4'd4, 4'd2, 4'd2};
    localparam logic [3:0]  PRIOS = 4'b0010;

    typedef struct packed {
        logic        who;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  c_req = '0, c_we = '0, l_req = '0, l_we = '0;
    logic [3:0]  c_gnt, c_done, l_gnt, l_done, m_en, m_we, busy;
    logic [31:0] c_addr [4];
    logic [31:0] c_wdata [4];
    logic [31:0] l_addr [4];
    logic [31:0] l_wdata [4];
    logic [31:0] c_rdata [4];
    logic [31:0] l_rdata [4];
    logic [31:0] m_addr [4];
    logic [31:0] m_wdata [4];
    logic [31:0] m_rdata [4];

    exp_t sb[$];
    int   vecs = 0;
    int   errs = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_inst
        localparam int LAT = int'(LATS[g*4 +: 4]);
        localparam int PR  = int'(PRIOS[g]);
        logic [31:0] mem  [0:255];
        logic [31:0] pipe [0:15];

        always @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 + 32'(i);
                mem[64] <= 32'hDEADBEEF;
                for (int i = 0; i < 16; i++) pipe[i] <= '0;
            end else begin
                if (m_en[g] && m_we[g]) mem[m_addr[g][9:2]] <= m_wdata[g];
                pipe[0] <= (m_en[g] && !m_we[g]) ? mem[m_addr[g][9:2]] : 32'h0;
                for (int i = 1; i < 16; i++) pipe[i] <= pipe[i-1];
            end
        end
        assign m_rdata[g] = pipe[LAT-1];

        unified_mem_arbiter #(
            .ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .CORE_PRIO(PR)
        ) u_dut (
            .clk(clk), .reset(reset),
            .c_req(c_req[g]), .c_we(c_we[g]), .c_addr(c_addr[g]), .c_wdata(c_wdata[g]),
            .c_gnt(c_gnt[g]), .c_done(c_done[g]), .c_rdata(c_rdata[g]),
            .l_req(l_req[g]), .l_we(l_we[g]), .l_addr(l_addr[g]), .l_wdata(l_wdata[g]),
            .l_gnt(l_gnt[g]), .l_done(l_done[g]), .l_rdata(l_rdata[g]),
            .m_en(m_en[g]), .m_we(m_we[g]), .m_addr(m_addr[g]), .m_wdata(m_wdata[g]),
            .m_rdata(m_rdata[g]), .busy(busy[g])
        );
    end

    function automatic logic [166:0] obs(int g);
        return {c_gnt[g], c_done[g], l_gnt[g], l_done[g], m_en[g], m_we[g], busy[g],
                m_addr[g], m_wdata[g], c_rdata[g], l_rdata[g]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        c_req = '0; c_we = '0; l_req = '0; l_we = '0;
        for (int g = 0; g < 4; g++) begin
            c_addr[g] = '0; c_wdata[g] = '0; l_addr[g] = '0; l_wdata[g] = '0;
        end
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        apply_reset();
        reset = 1'b1;
        #1;
        for (int g = 0; g < 4; g++) begin
            vecs++;
            if (obs(g) !== '0) begin
                errs++;
                $display("FAIL reset_outputs[%0d] got %h expected 0", g, obs(g));
            end
        end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_core_read();
        exp_t e;
        apply_reset();
        c_we[0] = 1'b0; c_addr[0] = 32'h100; c_req[0] = 1'b1;
        sb.push_back('{who: 1'b0, data: 32'hDEADBEEF});
        tick();
        vecs++;
        if ({m_en[0], c_gnt[0], l_gnt[0], c_done[0], busy[0]} !== 5'b11001) begin
            errs++;
            $display("FAIL core_read_issue got %b expected 11001",
                     {m_en[0], c_gnt[0], l_gnt[0], c_done[0], busy[0]});
        end
        vecs++;
        if (m_addr[0] !== 32'h100 || m_we[0] !== 1'b0) begin
            errs++;
            $display("FAIL core_read_cmd got addr %h we %b expected 100 0", m_addr[0], m_we[0]);
        end
        tick();
        vecs++;
        if ({m_en[0], c_done[0], busy[0]} !== 3'b001) begin
            errs++;
            $display("FAIL core_read_wait got %b expected 001", {m_en[0], c_done[0], busy[0]});
        end
        tick();
        c_req[0] = 1'b0;
        vecs++;
        if ({c_done[0], l_done[0], l_gnt[0], busy[0]} !== 4'b1001) begin
            errs++;
            $display("FAIL core_read_done got %b expected 1001",
                     {c_done[0], l_done[0], l_gnt[0], busy[0]});
        end
        if (c_done[0] && sb.size() > 0) begin
            e = sb.pop_front();
            vecs++;
            if (c_rdata[0] !== e.data) begin
                errs++;
                $display("FAIL core_read_data got %h expected %h", c_rdata[0], e.data);
            end
        end
        vecs++;
        if (l_rdata[0] !== '0) begin
            errs++;
            $display("FAIL core_read_l_rdata got %h expected 0", l_rdata[0]);
        end
        tick();
        vecs++;
        if ({busy[0], c_done[0], m_en[0]} !== 3'b000) begin
            errs++;
            $display("FAIL core_read_idle got %b expected 000", {busy[0], c_done[0], m_en[0]});
        end
    endtask

    task automatic test_round_robin();
        logic exp_who[$];
        logic w;
        exp_t e;
        int   ngnt = 0, ndone = 0;
        apply_reset();
        exp_who = '{1'b0, 1'b1, 1'b0, 1'b1};
        c_addr[0] = 32'h100; l_addr[0] = 32'h104;
        c_req[0] = 1'b1; l_req[0] = 1'b1;
        for (int cyc = 0; cyc < 40 && ndone < 4; cyc++) begin
            tick();
            if (c_gnt[0] || l_gnt[0]) begin
                w = (exp_who.size() > 0) ? exp_who.pop_front() : ~l_gnt[0];
                vecs++;
                if (l_gnt[0] !== w || c_gnt[0] === l_gnt[0]) begin
                    errs++;
                    $display("FAIL rr_grant[%0d] got c%b l%b expected loader=%b",
                             ngnt, c_gnt[0], l_gnt[0], w);
                end
                sb.push_back('{who: w, data: w ? 32'hA000_0041 : 32'hDEADBEEF});
                ngnt++;
                if (ngnt == 4) begin c_req[0] = 1'b0; l_req[0] = 1'b0; end
            end
            if (c_done[0] || l_done[0]) begin
                vecs++;
                if (sb.size() == 0) begin
                    errs++;
                    $display("FAIL rr_done unexpected got done expected none");
                end else begin
                    e = sb.pop_front();
                    if (l_done[0] !== e.who || (e.who ? l_rdata[0] : c_rdata[0]) !== e.data) begin
                        errs++;
                        $display("FAIL rr_done[%0d] got l%b c%h l%h expected loader=%b %h",
                                 ndone, l_done[0], c_rdata[0], l_rdata[0], e.who, e.data);
                    end
                end
                ndone++;
            end
        end
        vecs++;
        if (ngnt != 4 || ndone != 4) begin
            errs++;
            $display("FAIL rr_timeout got %0d grants %0d dones expected 4 4", ngnt, ndone);
        end
    endtask

    task automatic test_fixed_prio();
        logic exp_who[$];
        logic w;
        exp_t e;
        int   ngnt = 0, ndone = 0;
        apply_reset();
        exp_who = '{1'b0, 1'b0, 1'b0, 1'b1};
        c_addr[1] = 32'h100; l_addr[1] = 32'h104;
        c_req[1] = 1'b1; l_req[1] = 1'b1;
        for (int cyc = 0; cyc < 40 && ndone < 4; cyc++) begin
            tick();
            if (c_gnt[1] || l_gnt[1]) begin
                w = (exp_who.size() > 0) ? exp_who.pop_front() : ~l_gnt[1];
                vecs++;
                if (l_gnt[1] !== w || c_gnt[1] === l_gnt[1]) begin
                    errs++;
                    $display("FAIL prio_grant[%0d] got c%b l%b expected loader=%b",
                             ngnt, c_gnt[1], l_gnt[1], w);
                end
                sb.push_back('{who: w, data: w ? 32'hA000_0041 : 32'hDEADBEEF});
                ngnt++;
                if (ngnt == 3) c_req[1] = 1'b0;
                if (ngnt == 4) l_req[1] = 1'b0;
            end
            if (c_done[1] || l_done[1]) begin
                vecs++;
                if (sb.size() == 0) begin
                    errs++;
                    $display("FAIL prio_done unexpected got done expected none");
                end else begin
                    e = sb.pop_front();
                    if (l_done[1] !== e.who || (e.who ? l_rdata[1] : c_rdata[1]) !== e.data) begin
                        errs++;
                        $display("FAIL prio_done[%0d] got l%b c%h l%h expected loader=%b %h",
                                 ndone, l_done[1], c_rdata[1], l_rdata[1], e.who, e.data);
                    end
                end
                ndone++;
            end
        end
        vecs++;
        if (ngnt != 4 || ndone != 4) begin
            errs++;
            $display("FAIL prio_timeout got %0d grants %0d dones expected 4 4", ngnt, ndone);
        end
    endtask

    task automatic test_write_then_read();
        exp_t e;
        apply_reset();
        l_we[0] = 1'b1; l_addr[0] = 32'h40; l_wdata[0] = 32'h55AA55AA; l_req[0] = 1'b1;
        tick();
        vecs++;
        if ({l_gnt[0], l_done[0], c_gnt[0], c_done[0], m_en[0], m_we[0]} !== 6'b110011
            || m_addr[0] !== 32'h40 || m_wdata[0] !== 32'h55AA55AA) begin
            errs++;
            $display("FAIL wr_issue got %b %h %h expected 110011 40 55aa55aa",
                     {l_gnt[0], l_done[0], c_gnt[0], c_done[0], m_en[0], m_we[0]},
                     m_addr[0], m_wdata[0]);
        end
        l_req[0] = 1'b0;
        c_we[0] = 1'b0; c_addr[0] = 32'h40; c_req[0] = 1'b1;
        sb.push_back('{who: 1'b0, data: 32'h55AA55AA});
        tick();
        vecs++;
        if ({busy[0], l_done[0], c_gnt[0]} !== 3'b000) begin
            errs++;
            $display("FAIL wr_idle got %b expected 000", {busy[0], l_done[0], c_gnt[0]});
        end
        tick();
        vecs++;
        if ({c_gnt[0], l_gnt[0], m_we[0]} !== 3'b100 || m_addr[0] !== 32'h40) begin
            errs++;
            $display("FAIL rd_after_wr_issue got %b %h expected 100 40",
                     {c_gnt[0], l_gnt[0], m_we[0]}, m_addr[0]);
        end
        tick();
        tick();
        c_req[0] = 1'b0;
        vecs++;
        if (!c_done[0] || sb.size() == 0) begin
            errs++;
            $display("FAIL rd_after_wr_done got %b expected 1", c_done[0]);
        end else begin
            e = sb.pop_front();
            if (c_rdata[0] !== e.data) begin
                errs++;
                $display("FAIL rd_after_wr_data got %h expected %h", c_rdata[0], e.data);
            end
        end
        tick();
    endtask

    task automatic test_reset_mid_read();
        exp_t e;
        int   stray = 0;
        apply_reset();
        c_we[2] = 1'b0; c_addr[2] = 32'h100; c_req[2] = 1'b1;
        tick();
        vecs++;
        if (c_gnt[2] !== 1'b1) begin
            errs++;
            $display("FAIL abort_issue got %b expected 1", c_gnt[2]);
        end
        tick();
        tick();
        reset = 1'b1;
        c_req[2] = 1'b0;
        #1;
        vecs++;
        if (obs(2) !== '0) begin
            errs++;
            $display("FAIL abort_outputs got %h expected 0", obs(2));
        end
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (c_done[2] || l_done[2] || busy[2]) stray++;
        end
        vecs++;
        if (stray != 0) begin
            errs++;
            $display("FAIL abort_no_done got %0d active cycles expected 0", stray);
        end
        c_addr[2] = 32'h100; l_addr[2] = 32'h104;
        c_req[2] = 1'b1; l_req[2] = 1'b1;
        sb.push_back('{who: 1'b0, data: 32'hDEADBEEF});
        tick();
        vecs++;
        if ({c_gnt[2], l_gnt[2]} !== 2'b10) begin
            errs++;
            $display("FAIL post_abort_grant got %b expected 10", {c_gnt[2], l_gnt[2]});
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (c_done[2]) stray++;
        end
        tick();
        c_req[2] = 1'b0; l_req[2] = 1'b0;
        vecs++;
        if (stray != 0 || !c_done[2] || sb.size() == 0) begin
            errs++;
            $display("FAIL post_abort_done got done %b early %0d expected 1 0", c_done[2], stray);
        end else begin
            e = sb.pop_front();
            if (c_rdata[2] !== e.data) begin
                errs++;
                $display("FAIL post_abort_data got %h expected %h", c_rdata[2], e.data);
            end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        apply_reset();
        c_we[3] = 1'b0; c_addr[3] = 32'h100; c_req[3] = 1'b1;
        sb.push_back('{who: 1'b0, data: 32'hDEADBEEF});
        tick();
        vecs++;
        if ({c_gnt[3], c_done[3]} !== 2'b10) begin
            errs++;
            $display("FAIL lat1_issue got %b expected 10", {c_gnt[3], c_done[3]});
        end
        tick();
        vecs++;
        if (!c_done[3] || c_gnt[3] || sb.size() == 0) begin
            errs++;
            $display("FAIL lat1_done got done %b gnt %b expected 1 0", c_done[3], c_gnt[3]);
        end else begin
            e = sb.pop_front();
            if (c_rdata[3] !== e.data) begin
                errs++;
                $display("FAIL lat1_data got %h expected %h", c_rdata[3], e.data);
            end
        end
        c_addr[3] = 32'h104;
        sb.push_back('{who: 1'b0, data: 32'hA000_0041});
        tick();
        vecs++;
        if ({busy[3], c_gnt[3], c_done[3]} !== 3'b000) begin
            errs++;
            $display("FAIL b2b_idle got %b expected 000", {busy[3], c_gnt[3], c_done[3]});
        end
        tick();
        c_req[3] = 1'b0;
        vecs++;
        if (c_gnt[3] !== 1'b1 || m_addr[3] !== 32'h104) begin
            errs++;
            $display("FAIL b2b_second_issue got %b %h expected 1 104", c_gnt[3], m_addr[3]);
        end
        tick();
        vecs++;
        if (!c_done[3] || sb.size() == 0) begin
            errs++;
            $display("FAIL b2b_second_done got %b expected 1", c_done[3]);
        end else begin
            e = sb.pop_front();
            if (c_rdata[3] !== e.data) begin
                errs++;
                $display("FAIL b2b_second_data got %h expected %h", c_rdata[3], e.data);
            end
        end
        tick();
        vecs++;
        if ({busy[3], c_gnt[3]} !== 2'b00) begin
            errs++;
            $display("FAIL b2b_no_third got %b expected 00", {busy[3], c_gnt[3]});
        end
    endtask

    initial begin
        test_reset();
        test_core_read();
        test_round_robin();
        test_fixed_prio();
        test_write_then_read();
        test_reset_mid_read();
        test_back_to_back();
        vecs++;
        if (sb.size() != 0) begin
            errs++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
